count_dreg_unit: RTL and testbench

Combined storage primitive: a loadable up-counter plus an enabled D register sharing one clock and reset. Controllers use the counter for cycle and burst counting, with a combinational compare outside the block. They use the register to latch bus values such as the start address or burst code. Both halves are fully independent apart from the shared clock and reset.

---
 rtl/count_dreg_unit.sv | 57 +++++
 tb/tb_count_dreg_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/count_dreg_unit.sv
// Loadable up-counter plus an enabled D register sharing clock and asynchronous reset.
// Define COUNT_SATURATE_EN to make the counter stop at all-ones instead of wrapping.
module count_dreg_unit #(
   parameter int COUNT_WIDTH = 4,
   parameter int D_WIDTH     = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   count_en,
   input  logic                   load,
   input  logic [COUNT_WIDTH-1:0] count_load,
   output logic [COUNT_WIDTH-1:0] count,
   input  logic                   reg_en,
   input  logic [D_WIDTH-1:0]     d,
   output logic [D_WIDTH-1:0]     q
);

   localparam logic [COUNT_WIDTH-1:0] count_one = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] count_max = '1;

   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [D_WIDTH-1:0]     q_q, q_d;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = count_load;
      end else if (count_en) begin
`ifdef COUNT_SATURATE_EN
         if (count_q != count_max) count_d = count_q + count_one;
`else
         count_d = count_q + count_one;
`endif
      end
   end

   always_comb begin
      q_d = q_q;
      if (reg_en) q_d = d;
   end

   // NOTE: state is updated with non-blocking assignments only, so all flops sample the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         q_q     <= '0;
      end else begin
         count_q <= count_d;
         q_q     <= q_d;
      end
   end

   assign count = count_q;
   assign q     = q_q;

endmodule

// File: tb/tb_count_dreg_unit.sv
// Randomised bench: two widths of count_dreg_unit checked every cycle against an arithmetic model,
// plus literal expectations for reset, wrap/saturate, load priority, hold and register capture.
module tb_count_dreg_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        count_en = 1'b0;
   logic        load = 1'b0;
   logic [3:0]  count_load = '0;
   logic        reg_en = 1'b0;
   logic [31:0] d = '0;

   logic [1:0]  count_a;
   logic [31:0] q_a;
   logic [2:0]  count_b;
   logic [22:0] q_b;

   int tests_run = 0;
   int tests_failed = 0;
   bit compare_on = 1'b0;

   // Reference state as plain integers
   int unsigned m_cnt_a = 0, m_cnt_b = 0;
   longint unsigned m_q_a = 0, m_q_b = 0;

   always #5 clk = ~clk;

   count_dreg_unit #(.COUNT_WIDTH(2), .D_WIDTH(32)) dut_a (
      .clk(clk), .rst(rst), .count_en(count_en), .load(load),
      .count_load(count_load[1:0]), .count(count_a),
      .reg_en(reg_en), .d(d), .q(q_a)
   );

   count_dreg_unit #(.COUNT_WIDTH(3), .D_WIDTH(23)) dut_b (
      .clk(clk), .rst(rst), .count_en(count_en), .load(load),
      .count_load(count_load[2:0]), .count(count_b),
      .reg_en(reg_en), .d(d[22:0]), .q(q_b)
   );

   function automatic int unsigned next_count(int unsigned cur, int unsigned modulus);
      int unsigned r;
      r = cur;
      if (load) r = count_load % modulus;
      else if (count_en) begin
`ifdef COUNT_SATURATE_EN
         r = (cur == modulus - 1) ? cur : cur + 1;
`else
         r = (cur + 1) % modulus;
`endif
      end
      return r;
   endfunction

   always @(posedge rst) begin
      m_cnt_a = 0; m_cnt_b = 0; m_q_a = 0; m_q_b = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_cnt_a = 0; m_cnt_b = 0; m_q_a = 0; m_q_b = 0;
      end else begin
         m_cnt_a = next_count(m_cnt_a, 4);
         m_cnt_b = next_count(m_cnt_b, 8);
         if (reg_en) begin
            m_q_a = d;
            m_q_b = d % (64'd1 << 23);
         end
      end
   end

   task automatic check(input string name, input longint unsigned actual, input longint unsigned expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (compare_on) begin
         check("model count_a", count_a, m_cnt_a);
         check("model q_a", q_a, m_q_a);
         check("model count_b", count_b, m_cnt_b);
         check("model q_b", q_b, m_q_b);
      end
   end

   // Drive inputs just after a falling edge, then wait for the next falling edge
   task automatic step(input logic en, input logic ld, input logic [3:0] cl,
                       input logic ren, input logic [31:0] dd);
      #1;
      count_en = en; load = ld; count_load = cl; reg_en = ren; d = dd;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset count_a", count_a, 0);
      check("reset q_a", q_a, 0);
      #1 rst = 1'b0;
      @(negedge clk);
      compare_on = 1'b1;

      // Async reset from count=2, q=DEADBEEF, no clock edge needed
      step(1'b0, 1'b1, 4'd2, 1'b1, 32'hDEADBEEF);
      check("pre-reset count_a", count_a, 2);
      check("pre-reset q_a", q_a, 32'hDEADBEEF);
      #1 count_en = 1'b1; load = 1'b0; reg_en = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("async count_a", count_a, 0);
      check("async q_a", q_a, 0);
      @(negedge clk);
      check("held count_a", count_a, 0);
      check("held q_a", q_a, 0);
      #1 rst = 1'b0; count_en = 1'b0;
      @(negedge clk);

      // Count and wrap / saturate on the 2-bit counter
      step(1'b1, 1'b0, 4'd0, 1'b0, 32'd0); check("wrap 1", count_a, 1);
      step(1'b1, 1'b0, 4'd0, 1'b0, 32'd0); check("wrap 2", count_a, 2);
      step(1'b1, 1'b0, 4'd0, 1'b0, 32'd0); check("wrap 3", count_a, 3);
`ifdef COUNT_SATURATE_EN
      step(1'b1, 1'b0, 4'd0, 1'b0, 32'd0); check("sat 4", count_a, 3);
      step(1'b1, 1'b0, 4'd0, 1'b0, 32'd0); check("sat 5", count_a, 3);
`else
      step(1'b1, 1'b0, 4'd0, 1'b0, 32'd0); check("wrap 4", count_a, 0);
      step(1'b1, 1'b0, 4'd0, 1'b0, 32'd0); check("wrap 5", count_a, 1);
`endif

      // Load beats count_en on the 3-bit counter
      step(1'b1, 1'b1, 4'd5, 1'b0, 32'd0); check("load prio", count_b, 5);
      step(1'b1, 1'b0, 4'd0, 1'b0, 32'd0); check("after load", count_b, 6);

      // Load all-ones then count
      step(1'b0, 1'b1, 4'd7, 1'b0, 32'd0);
      step(1'b1, 1'b0, 4'd0, 1'b0, 32'd0);
`ifdef COUNT_SATURATE_EN
      check("max+1 b", count_b, 7);
`else
      check("max+1 b", count_b, 0);
`endif

      // Hold at 3
      step(1'b0, 1'b1, 4'd3, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
         check("hold b", count_b, 3);
      end

      // 23-bit register capture and hold
      step(1'b0, 1'b0, 4'd0, 1'b1, 32'h007ABCDE); check("capture q_b", q_b, 23'h7ABCDE);
      step(1'b0, 1'b0, 4'd0, 1'b0, 32'h00000123); check("hold q_b", q_b, 23'h7ABCDE);

      // Short reset pulse between edges
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      check("pulse count_b", count_b, 0);
      check("pulse q_b", q_b, 0);
      @(negedge clk);

      // Random traffic with occasional short resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
            @(negedge clk);
         end else begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                 4'($urandom), 1'($urandom), $urandom);
         end
      end

      compare_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
